// File: rtl/instruction_fetch.sv
// instruction_fetch: per-core fetch stage feeding the instruction decoder.
// Holds the program counter, issues one read request at a time to
// instruction memory and hands each word with its PC to decode over a
// valid/ready handshake. Supports launch, redirect from execute, and stops
// after delivering a HALT word.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_start, i_start_pc        launch pulse and first PC (IDLE/DONE only)
//   i_redirect_valid/_pc       redirect request from execute
//   o_mem_req_valid/_addr      memory read request (addr = PC)
//   i_mem_req_ready            memory accepts the request
//   i_mem_rsp_valid/_data      read response, one per accepted request
//   o_instr_valid/_word/_pc    instruction to decode
//   i_instr_ready              decode accepts the instruction
//   o_busy, o_done             REQ/WAIT/HOLD/FLUSH, and DONE
//
// Optional feature (macro FETCH_PERF_CNT_EN): adds saturating counters
//   o_fetch_count (instructions accepted by decode) and o_stall_count
//   (cycles spent in WAIT or FLUSH).
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_pc,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  input  logic                  i_mem_req_ready,
  input  logic                  i_mem_rsp_valid,
  input  logic [31:0]           i_mem_rsp_data,
  output logic                  o_instr_valid,
  output logic [31:0]           o_instr_word,
  output logic [ADDR_WIDTH-1:0] o_instr_pc,
  input  logic                  i_instr_ready,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           o_fetch_count,
  output logic [31:0]           o_stall_count,
`endif
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {
    StIdle, StReq, StWait, StHold, StFlush, StDone
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PcOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;

  logic launch;
  logic consume;

  assign launch  = ((state_q == StIdle) || (state_q == StDone)) && i_start;
  // Redirect wins over a coincident handshake: the word is not consumed.
  assign consume = (state_q == StHold) && i_instr_ready && !i_redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    word_d  = word_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          pc_d    = i_start_pc;
          state_d = StReq;
        end
      end
      StReq: begin
        if (i_redirect_valid) begin
          pc_d    = i_redirect_pc;
          // If the old request is accepted this cycle its response must be drained.
          state_d = i_mem_req_ready ? StFlush : StReq;
        end else if (i_mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (i_redirect_valid) begin
          pc_d    = i_redirect_pc;
          state_d = i_mem_rsp_valid ? StReq : StFlush;
        end else if (i_mem_rsp_valid) begin
          word_d  = i_mem_rsp_data;
          ipc_d   = pc_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (i_redirect_valid) begin
          pc_d    = i_redirect_pc;
          state_d = StReq;
        end else if (i_instr_ready) begin
          if (word_q[31:27] == HALT_OPCODE) begin
            state_d = StDone;
          end else begin
            pc_d    = pc_q + PcOne;
            state_d = StReq;
          end
        end
      end
      StFlush: begin
        if (i_redirect_valid) begin
          pc_d = i_redirect_pc;
        end
        // Once the stale response drains nothing is outstanding, so a coincident
        // redirect just retargets the next request.
        if (i_mem_rsp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      word_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      ipc_q   <= ipc_d;
    end
  end

  assign o_mem_req_valid = (state_q == StReq);
  assign o_mem_req_addr  = pc_q;
  assign o_instr_valid   = (state_q == StHold);
  assign o_instr_word    = word_q;
  assign o_instr_pc      = ipc_q;
  assign o_busy          = (state_q == StReq) || (state_q == StWait) ||
                           (state_q == StHold) || (state_q == StFlush);
  assign o_done          = (state_q == StDone);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (launch) begin
      fetch_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (consume && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (((state_q == StWait) || (state_q == StFlush)) &&
          (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_fetch_count = fetch_cnt_q;
  assign o_stall_count = stall_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = launch ^ consume;
`endif

endmodule
